// File: rtl/div_unit_pkg.sv
// Shared definitions for the EX-stage divider: state encodings, handshake levels
// and the ALU operation codes that select DIV / DIVU.
package div_unit_pkg;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_t;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

endpackage

// File: rtl/div_unit_if.sv
// EX <-> divider handshake bundle; master is the EX stage, slave is div_unit.
// With DIV_BYZERO_FLAG_EN defined the bundle also carries byzero_o.
interface div_unit_if #(parameter int WIDTH = 32);

    logic               signed_div_i;
    logic [WIDTH-1:0]   opdata1_i;
    logic [WIDTH-1:0]   opdata2_i;
    logic               start_i;
    logic               annul_i;
    logic [2*WIDTH-1:0] result_o;
    logic               ready_o;
`ifdef DIV_BYZERO_FLAG_EN
    logic               byzero_o;
`endif

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
`ifdef DIV_BYZERO_FLAG_EN
        input  byzero_o,
`endif
        input  result_o, ready_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
`ifdef DIV_BYZERO_FLAG_EN
        output byzero_o,
`endif
        output result_o, ready_o
    );

endinterface

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU; result is {remainder, quotient}.
// Optional divide-by-zero flag output is enabled with DIV_BYZERO_FLAG_EN.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic       clk,
    input  logic       rst,
    div_unit_if.slave  bus
);

    div_state_t         state;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH:0]   work;
    logic [WIDTH-1:0]   divisor;
    logic               signed_q;
    logic               sign1;
    logic               sign2;
    logic [2*WIDTH-1:0] result_q;
    logic               ready_q;
    logic               byzero_q;

    logic [WIDTH-1:0]   mag1;
    logic [WIDTH-1:0]   mag2;
    logic [2*WIDTH:0]   shifted;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   quo_raw;
    logic [WIDTH-1:0]   rem_raw;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    // Operand magnitudes at issue time, one restoring step, and final sign fix-up.
    always_comb begin
        mag1    = bus.opdata1_i;
        mag2    = bus.opdata2_i;
        if (bus.signed_div_i && bus.opdata1_i[WIDTH-1])
            mag1 = (~bus.opdata1_i) + 1'b1;
        if (bus.signed_div_i && bus.opdata2_i[WIDTH-1])
            mag2 = (~bus.opdata2_i) + 1'b1;

        shifted = work << 1;
        diff    = shifted[2*WIDTH:WIDTH] - {1'b0, divisor};

        quo_raw = work[WIDTH-1:0];
        rem_raw = work[2*WIDTH-1:WIDTH];
        quo_fix = quo_raw;
        rem_fix = rem_raw;
        if (signed_q && (sign1 ^ sign2))
            quo_fix = (~quo_raw) + 1'b1;
        if (signed_q && sign1)
            rem_fix = (~rem_raw) + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= DivFree;
            cnt      <= '0;
            work     <= '0;
            divisor  <= '0;
            signed_q <= 1'b0;
            sign1    <= 1'b0;
            sign2    <= 1'b0;
            result_q <= '0;
            ready_q  <= DivResultNotReady;
            byzero_q <= 1'b0;
        end else begin
            case (state)
                DivFree: begin
                    result_q <= '0;
                    ready_q  <= DivResultNotReady;
                    byzero_q <= 1'b0;
                    if (bus.start_i == DivStart && !bus.annul_i) begin
                        signed_q <= bus.signed_div_i;
                        sign1    <= bus.opdata1_i[WIDTH-1];
                        sign2    <= bus.opdata2_i[WIDTH-1];
                        divisor  <= mag2;
                        work     <= {{(WIDTH+1){1'b0}}, mag1};
                        cnt      <= '0;
                        if (bus.opdata2_i == '0)
                            state <= DivByZero;
                        else
                            state <= DivOn;
                    end
                end

                DivByZero: begin
                    work     <= '0;
                    result_q <= '0;
                    ready_q  <= DivResultReady;
                    byzero_q <= 1'b1;
                    state    <= DivEnd;
                end

                // A flush wins over both iteration and finalisation.
                DivOn: begin
                    if (bus.annul_i) begin
                        state <= DivFree;
                    end else if (cnt != CNT_W'(WIDTH)) begin
                        if (!diff[WIDTH])
                            work <= {diff, shifted[WIDTH-1:1], 1'b1};
                        else
                            work <= shifted;
                        cnt <= cnt + 1'b1;
                    end else begin
                        result_q <= {rem_fix, quo_fix};
                        ready_q  <= DivResultReady;
                        state    <= DivEnd;
                    end
                end

                DivEnd: begin
                    if (bus.start_i == DivStop) begin
                        state    <= DivFree;
                        result_q <= '0;
                        ready_q  <= DivResultNotReady;
                        byzero_q <= 1'b0;
                    end
                end

                default: state <= DivFree;
            endcase
        end
    end

    assign bus.result_o = result_q;
    assign bus.ready_o  = ready_q;

`ifdef DIV_BYZERO_FLAG_EN
    assign bus.byzero_o = byzero_q;
`else
    logic unused_byzero;
    assign unused_byzero = byzero_q;
`endif

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, signed/unsigned results, divide-by-zero,
// annul and reset recovery, with hand-computed expectations.
module tb_div_unit;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;
    int   edges;
    int   ready_seen;

    div_unit_if #(.WIDTH(32)) bus ();

    div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic sgn, input logic [31:0] a,
                                 input logic [31:0] b);
        bus.signed_div_i = sgn;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.annul_i      = 1'b0;
        bus.start_i      = 1'b1;
    endtask

    // Counts edges from the sampling edge (edge 1) until ready_o is seen; -1 on timeout.
    task automatic runDiv(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          output int n);
        applyStimulus(sgn, a, b);
        n = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            if (i == 1) begin
                bus.opdata1_i    = ~a;
                bus.opdata2_i    = b + 32'd3;
                bus.signed_div_i = ~sgn;
            end
            if (bus.ready_o) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic releaseStart(input string tag);
        bus.start_i = 1'b0;
        @(posedge clk); #1;
        checkOutput({tag, "_rel_ready"}, {63'd0, bus.ready_o}, 64'd0);
        checkOutput({tag, "_rel_result"}, bus.result_o, 64'd0);
    endtask

    task automatic watchIdle(input int cycles, output int seen);
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (bus.ready_o) seen++;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = '0;
        bus.opdata2_i    = '0;
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_ready", {63'd0, bus.ready_o}, 64'd0);
        checkOutput("reset_result", bus.result_o, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Unsigned 100 / 7 with END hold and annul ignored in END
        runDiv(1'b0, 32'd100, 32'd7, edges);
        checkOutput("u100_7_lat", 64'(edges), 64'd34);
        checkOutput("u100_7_res", bus.result_o, {32'h0000_0002, 32'h0000_000E});
`ifdef DIV_BYZERO_FLAG_EN
        checkOutput("u100_7_byzero", {63'd0, bus.byzero_o}, 64'd0);
`endif
        bus.annul_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.annul_i = 1'b0;
        checkOutput("u100_7_hold_ready", {63'd0, bus.ready_o}, 64'd1);
        checkOutput("u100_7_hold_res", bus.result_o, {32'h0000_0002, 32'h0000_000E});
        releaseStart("u100_7");

        // Signed -7 / 2 and 7 / -2
        runDiv(1'b1, 32'hFFFF_FFF9, 32'd2, edges);
        checkOutput("s_m7_2_lat", 64'(edges), 64'd34);
        checkOutput("s_m7_2_res", bus.result_o, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        releaseStart("s_m7_2");
        runDiv(1'b1, 32'd7, 32'hFFFF_FFFE, edges);
        checkOutput("s_7_m2_res", bus.result_o, {32'h0000_0001, 32'hFFFF_FFFD});
        releaseStart("s_7_m2");

        // Same bit pattern unsigned: 0xFFFFFFF9 / 2
        runDiv(1'b0, 32'hFFFF_FFF9, 32'd2, edges);
        checkOutput("u_fff9_2_res", bus.result_o, {32'h0000_0001, 32'h7FFF_FFFC});
        releaseStart("u_fff9_2");

        // Divide by zero
        runDiv(1'b0, 32'h0000_1234, 32'd0, edges);
        checkOutput("byzero_lat", 64'(edges), 64'd2);
        checkOutput("byzero_res", bus.result_o, 64'd0);
`ifdef DIV_BYZERO_FLAG_EN
        checkOutput("byzero_flag", {63'd0, bus.byzero_o}, 64'd1);
`endif
        releaseStart("byzero");
`ifdef DIV_BYZERO_FLAG_EN
        checkOutput("byzero_flag_clr", {63'd0, bus.byzero_o}, 64'd0);
`endif

        // start with annul in FREE must be ignored
        applyStimulus(1'b0, 32'd50, 32'd5);
        bus.annul_i = 1'b1;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        bus.annul_i = 1'b0;
        watchIdle(40, ready_seen);
        checkOutput("start_annul_ignored", 64'(ready_seen), 64'd0);

        // Annul at iteration 10, then a fresh unsigned request
        applyStimulus(1'b0, 32'd12345, 32'd3);
        repeat (11) @(posedge clk);
        #1;
        bus.annul_i = 1'b1;
        bus.start_i = 1'b0;
        @(posedge clk); #1;
        bus.annul_i = 1'b0;
        watchIdle(40, ready_seen);
        checkOutput("annul_no_ready", 64'(ready_seen), 64'd0);
        runDiv(1'b0, 32'hFFFF_FFFF, 32'h0000_0010, edges);
        checkOutput("after_annul_lat", 64'(edges), 64'd34);
        checkOutput("after_annul_res", bus.result_o, {32'h0000_000F, 32'h0FFF_FFFF});
        releaseStart("after_annul");

        // Signed overflow wraps
        runDiv(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, edges);
        checkOutput("ovf_res", bus.result_o, {32'h0000_0000, 32'h8000_0000});
        releaseStart("ovf");

        // Reset in the middle of ON, then a normal division
        applyStimulus(1'b0, 32'd999, 32'd9);
        repeat (15) @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("midrst_ready", {63'd0, bus.ready_o}, 64'd0);
        checkOutput("midrst_result", bus.result_o, 64'd0);
        rst = 1'b0;
        watchIdle(40, ready_seen);
        checkOutput("midrst_idle", 64'(ready_seen), 64'd0);
        runDiv(1'b1, 32'd1000, 32'd33, edges);
        checkOutput("post_rst_lat", 64'(edges), 64'd34);
        checkOutput("post_rst_res", bus.result_o, {32'd10, 32'd30});
        releaseStart("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle radix-2 restoring divider; the responder on the EX-stage divide handshake.
- EX issues operands with start_i and stalls the pipeline until ready_o.
- EX then forwards result_o to the HI/LO write path: LO = quotient, HI = remainder.
- Serves DIV (signed) and DIVU (unsigned) in the OpenMIPS-style 5-stage core.

Parameters:
- WIDTH, 32, operand width; result_o is 2*WIDTH.
- CNT_W, 6, iteration counter width; must hold the value WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start_i
- opdata1_i  in  WIDTH  dividend; sampled with start_i
- opdata2_i  in  WIDTH  divisor; sampled with start_i
- start_i  in  1  request; held high by EX until it has consumed ready_o
- annul_i  in  1  abort the current division (branch flush / exception)
- result_o  out  2*WIDTH  {remainder, quotient}
- ready_o  out  1  result valid

Behaviour:
- Reset (rst high at a clock edge):
  - state = FREE, result_o = 0, ready_o = 0, counter = 0.
  - Any division in progress is discarded.
- State FREE:
  - ready_o = 0, result_o = 0.
  - If start_i=1 and annul_i=0:
    - Latch signed_div_i.
    - If signed, latch the magnitudes of the operands (two's-complement negate when MSB=1); otherwise latch them raw.
    - Latch the sign of each operand.
    - If opdata2_i == 0, go to BYZERO.
    - Otherwise go to ON: work register (2*WIDTH+1 bits) = {WIDTH+1 zeros, |dividend|}, counter = 0.
- State BYZERO:
  - Next edge goes to END with quotient = 0 and remainder = 0.
- State ON, one iteration per edge while counter < WIDTH:
  - Shift the work register left by 1.
  - Trial-subtract the divisor from the upper WIDTH+1 bits.
  - If the difference is non-negative, keep it and set quotient bit 0 = 1; else keep the shifted value and set bit 0 = 0.
  - counter += 1.
  - At the edge where counter == WIDTH, go to END.
  - annul_i=1 on any edge in ON: go to FREE, ready_o stays 0, no result.
- Entering END:
  - Apply sign correction when signed: quotient negated if the operand signs differ; remainder takes the dividend's sign.
  - Register result_o = {remainder, quotient}, ready_o = 1.
- State END:
  - Hold result_o and ready_o while start_i=1.
  - On the edge that sees start_i=0: go to FREE, ready_o = 0, result_o = 0.
  - annul_i is ignored in END.
- Latency: ready_o rises 34 edges after the edge that sampled start_i (1 load + 32 iterations + 1 finalise); 2 edges for divide-by-zero.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0 (natural wrap, no trap).
- start_i=1 together with annul_i=1 in FREE: request ignored, stay in FREE.
- Operand changes after sampling have no effect.
- No new request is accepted until the unit has returned to FREE.

Optional Feature:
- Macro DIV_BYZERO_FLAG_EN.
- Defined: adds output byzero_o (1 bit, reset 0). It is asserted alongside ready_o when the sampled divisor was 0, and cleared on the return to FREE.
- Undefined: no port; divide-by-zero is observable only as result 0.

Decomposition:
- Shared defines file gets:
  - state encodings DivFree, DivByZero, DivOn, DivEnd (2 bits);
  - DivResultReady / DivResultNotReady;
  - DivStart / DivStop;
  - EXE_DIV_OP / EXE_DIVU_OP aluop codes.
- Single module; no natural sub-module (the abs/negate helpers are inline expressions).

Test Plan:
- Unsigned 100 / 7, start held → ready_o high exactly 34 edges later; result_o = {0x00000002, 0x0000000E}; release start → ready_o = 0 next edge.
- Signed -7 / 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; signed 7 / -2 → quotient 0xFFFFFFFD, remainder 0x00000001.
- Divisor 0 (dividend 0x1234) → ready_o after 2 edges, result_o = 0; with DIV_BYZERO_FLAG_EN, byzero_o = 1.
- annul_i pulsed at iteration 10 → FREE, ready_o never rises; next start 0xFFFFFFFF / 0x10 (unsigned) → quotient 0x0FFFFFFF, remainder 0xF.
- Signed 0x80000000 / 0xFFFFFFFF → result_o = {0x00000000, 0x80000000}.
- rst asserted mid-ON → next edge ready_o = 0, result_o = 0; a later start completes normally in 34 edges.
